call_fsm: RTL and testbench
===========================

// Module: call_fsm
// PURPOSE
//   Decode-stage CALL sequencer for the 5-stage pipeline. A CALL is split into two
//   injected PUSH micro-ops: push PC low, then push PC high. Fetch stalls while both run.
//   The call target (Rdst value) is held on pc for the fetch unit for the whole sequence.
// PARAMETERS
//   DATA_W           16                   width of rdst_value and out
//   PC_W             32                   width of pc; rdst_value is zero-extended
//   PUSH_PC_LOW_OP   16'b0110000000001000 (16'h6008) instruction word: push PC low half
//   PUSH_PC_HIGH_OP  16'b0110000000001001 (16'h6009) instruction word: push PC high half
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high reset
//   call        in   1       CALL decoded this cycle; sampled on rising clk
//   rdst_value  in   DATA_W  call target address (Rdst register value)
//   out         out  DATA_W  injected instruction word (registered)
//   pc          out  PC_W    latched call target, zero-extended (registered)
//   stall       out  1       1 = freeze fetch/PC while the PUSH pair is injected (registered)
// BEHAVIOUR
//   - Moore FSM; all outputs registered; one clock domain.
//   - States: IDLE, PUSH_LOW, PUSH_HIGH. Encoding is 2-bit; the unused code recovers to IDLE.
//   - reset=1 forces the following at once, independent of clk:
//     state=IDLE, out=PUSH_PC_LOW_OP, stall=0, pc=0.
//   - IDLE:
//     - call=1 at an edge -> PUSH_LOW; pc <= {16'b0, rdst_value}.
//     - call=0 -> stay in IDLE.
//   - PUSH_LOW: always moves to PUSH_HIGH on the next edge. call is ignored; pc holds.
//   - PUSH_HIGH: always moves to IDLE on the next edge; pc clears to 0.
//     call is ignored (see CONFIGURATION).
//   - Outputs by state:
//     - IDLE:      out=PUSH_PC_LOW_OP, stall=0, pc=0
//     - PUSH_LOW:  out=PUSH_PC_LOW_OP, stall=1, pc=latched target
//     - PUSH_HIGH: out=PUSH_PC_HIGH_OP, stall=1, pc=latched target
//   - Latency: call sampled at edge N -> LOW op visible after N; HIGH op after N+1;
//     IDLE after N+2. stall is high for exactly 2 cycles per CALL.
//   - Consumers qualify out with stall. The IDLE value of out has no meaning.
//   - rdst_value is sampled only on the IDLE->PUSH_LOW edge. Later changes do not affect pc.
//   - call held high continuously: one sequence, then a new one starts from IDLE.
//     The gap between sequences is one IDLE cycle.
//   - Reset in PUSH_LOW or PUSH_HIGH aborts the sequence at once. No partial push resumes.
// CONFIGURATION
//   CALL_FSM_PENDING_EN
//     - Defined: a call=1 seen in PUSH_LOW or PUSH_HIGH sets a 1-bit pending flag.
//       When pending is set, PUSH_HIGH goes directly to PUSH_LOW, loads pc from
//       rdst_value, and clears pending. There is no IDLE cycle in between.
//       reset clears pending.
//     - Undefined: call outside IDLE is ignored. No pending flag is built.
// STRUCTURE
//   - call_fsm_pkg holds:
//     - state enum (IDLE=2'd0, PUSH_LOW=2'd1, PUSH_HIGH=2'd2)
//     - PUSH_PC_LOW_OP and PUSH_PC_HIGH_OP
//     - DATA_W and PC_W defaults
//   - One sub-module, call_fsm_pc_latch: target register with load and clear,
//     async reset to 0, zero-extends DATA_W to PC_W.
//   - Next-state/output logic is a single combinational block plus the state register.
// TESTING
//   1. Pulse reset, then hold low -> out=16'h6008, stall=0, pc=0.
//   2. call=1, rdst_value=16'h0F0F for 1 clk:
//      after edge 1: out=16'h6008, stall=1, pc=32'h0000_0F0F.
//      after edge 2: out=16'h6009, stall=1, pc=32'h0000_0F0F.
//   3. Continue scenario 2 with call=0 and rdst_value=0: the next 4 cycles show
//      out=16'h6008, stall=0, pc=0.
//   4. call=1, rdst_value=16'hFF0F; set rdst_value=16'h1234 after edge 1 ->
//      pc stays 32'h0000_FF0F through PUSH_HIGH; HIGH op = 16'h6009.
//   5. Assert reset asynchronously mid-PUSH_LOW (between edges) -> outputs go
//      to IDLE values at once; after release, call=0 stays IDLE.
//   6. call held high for 6 cycles:
//      - without CALL_FSM_PENDING_EN: stall pattern 1,1,0,1,1,0.
//      - with CALL_FSM_PENDING_EN: stall stays 1 and out alternates 6008/6009.

Source files
------------

// File: rtl/call_fsm_pkg.sv
// Shared constants for the CALL sequencer: state codes, injected PUSH opcodes and default widths.
// Optional build macro: CALL_FSM_PENDING_EN (see call_fsm.sv).
package call_fsm_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int PC_W_DEF   = 32;

    localparam logic [15:0] PUSH_PC_LOW_OP  = 16'h6008;
    localparam logic [15:0] PUSH_PC_HIGH_OP = 16'h6009;

    // Two-bit state codes; code 2'd3 is unused and steers back to IDLE.
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PUSH_LOW  = 2'd1;
    localparam logic [1:0] PUSH_HIGH = 2'd2;

endpackage

// File: rtl/call_fsm_pc_latch.sv
// Call-target register: loads a zero-extended DATA_W value, clears to 0, async reset to 0.
module call_fsm_pc_latch #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [PC_W-1:0]   pc_o
);

    logic [PC_W-1:0] pc_q;

    // Load wins over clear so a back-to-back CALL can reuse the slot in the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else if (load_i) begin
            pc_q <= {{(PC_W-DATA_W){1'b0}}, data_i};
        end else if (clear_i) begin
            pc_q <= '0;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/call_fsm.sv
// Decode-stage CALL sequencer: injects PUSH PC low then PUSH PC high while stalling fetch.
// Optional build macro: CALL_FSM_PENDING_EN queues a CALL seen mid-sequence and chains it.
module call_fsm
    import call_fsm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              call,
    input  logic [DATA_W-1:0] rdst_value,
    output logic [DATA_W-1:0] out,
    output logic [PC_W-1:0]   pc,
    output logic              stall
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              stall_q, stall_d;
    logic              pcLoad, pcClear;

`ifdef CALL_FSM_PENDING_EN
    logic pending_q, pending_d;
`endif

    // Outputs are computed from the next state so they appear registered with the state.
    always_comb begin
        state_d = IDLE;
        pcLoad  = 1'b0;
`ifdef CALL_FSM_PENDING_EN
        pending_d = pending_q;
`endif
        case (state_q)
            IDLE: begin
                if (call) begin
                    state_d = PUSH_LOW;
                    pcLoad  = 1'b1;
                end
            end
            PUSH_LOW: begin
                state_d = PUSH_HIGH;
`ifdef CALL_FSM_PENDING_EN
                if (call) pending_d = 1'b1;
`endif
            end
            PUSH_HIGH: begin
`ifdef CALL_FSM_PENDING_EN
                if (pending_q || call) begin
                    state_d   = PUSH_LOW;
                    pcLoad    = 1'b1;
                    pending_d = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        pcClear = (state_d == IDLE);
        out_d   = (state_d == PUSH_HIGH) ? PUSH_PC_HIGH_OP : PUSH_PC_LOW_OP;
        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= PUSH_PC_LOW_OP;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            stall_q <= stall_d;
        end
    end

`ifdef CALL_FSM_PENDING_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending_q <= 1'b0;
        else       pending_q <= pending_d;
    end
`endif

    call_fsm_pc_latch #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_pc_latch (
        .clk     (clk),
        .reset   (reset),
        .load_i  (pcLoad),
        .clear_i (pcClear),
        .data_i  (rdst_value),
        .pc_o    (pc)
    );

    assign out   = out_q;
    assign stall = stall_q;

endmodule

// File: tb/tb_call_fsm.sv
// Self-checking bench for call_fsm: a beat-queue model checked every cycle plus directed literal checks.
// Honours CALL_FSM_PENDING_EN for the held-call expectations.
module tb_call_fsm;

    localparam logic [15:0] LOW_OP  = 16'h6008;
    localparam logic [15:0] HIGH_OP = 16'h6009;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        call = 1'b0;
    logic [15:0] rdst_value = 16'h0;
    logic [15:0] out;
    logic [31:0] pc;
    logic        stall;

    int assertCount = 0;
    int failCount   = 0;

    call_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .call       (call),
        .rdst_value (rdst_value),
        .out        (out),
        .pc         (pc),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // Model: each CALL becomes two queued beats; an empty queue means the idle outputs.
    typedef struct packed {
        logic [15:0] op;
        logic [31:0] target;
    } beat_t;

    beat_t       beatQ[$];
    beat_t       curBeat;
    logic        mBusy;
    logic        mPend;
    logic        wasBusy;
    logic        startNew;
    logic [15:0] mOut;
    logic [31:0] mPc;
    logic        mStall;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            beatQ.delete();
            mBusy = 1'b0;
            mPend = 1'b0;
        end else begin
            wasBusy  = mBusy;
            startNew = 1'b0;
            if (beatQ.size() > 0) begin
                curBeat = beatQ.pop_front();
                mBusy   = 1'b1;
            end else if (!wasBusy && call) begin
                startNew = 1'b1;
`ifdef CALL_FSM_PENDING_EN
            end else if (wasBusy && (mPend || call)) begin
                startNew = 1'b1;
`endif
            end else begin
                mBusy = 1'b0;
            end
            if (startNew) begin
                curBeat = '{op: LOW_OP,  target: {16'h0, rdst_value}};
                beatQ.push_back('{op: HIGH_OP, target: {16'h0, rdst_value}});
                mBusy = 1'b1;
                mPend = 1'b0;
            end else if (wasBusy && call) begin
`ifdef CALL_FSM_PENDING_EN
                mPend = 1'b1;
`endif
            end
        end
        mOut   = mBusy ? curBeat.op : LOW_OP;
        mPc    = mBusy ? curBeat.target : 32'h0;
        mStall = mBusy;
    end

    task automatic compareOne(input string name, input logic [31:0] actual, input logic [31:0] required);
        assertCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            compareOne("model.out",   {16'h0, out}, {16'h0, mOut});
            compareOne("model.stall", {31'h0, stall}, {31'h0, mStall});
            compareOne("model.pc",    pc, mPc);
        end
    end

    // Literal expectations checked against both the DUT and the model.
    task automatic checkOutput(input string name, input logic [15:0] expOut, input logic expStall,
                               input logic [31:0] expPc);
        compareOne({name, ".out"},   {16'h0, out}, {16'h0, expOut});
        compareOne({name, ".stall"}, {31'h0, stall}, {31'h0, expStall});
        compareOne({name, ".pc"},    pc, expPc);
        compareOne({name, ".model"}, {mOut, 15'h0, mStall}, {expOut, 15'h0, expStall});
        compareOne({name, ".modelPc"}, mPc, expPc);
    endtask

    task automatic applyStimulus(input logic callV, input logic [15:0] rdstV);
        call       = callV;
        rdst_value = rdstV;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] heldOut[6];
    logic        heldStall[6];
    logic [31:0] heldPc[6];

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset", LOW_OP, 1'b0, 32'h0);

        applyStimulus(1'b1, 16'h0F0F);
        call = 1'b0;
        rdst_value = 16'h0;
        checkOutput("s2.low", LOW_OP, 1'b1, 32'h0000_0F0F);
        @(posedge clk); #1;
        checkOutput("s2.high", HIGH_OP, 1'b1, 32'h0000_0F0F);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'h0);
            checkOutput("s3.idle", LOW_OP, 1'b0, 32'h0);
        end

        applyStimulus(1'b1, 16'hFF0F);
        call = 1'b0;
        rdst_value = 16'h1234;
        checkOutput("s4.low", LOW_OP, 1'b1, 32'h0000_FF0F);
        @(posedge clk); #1;
        checkOutput("s4.high", HIGH_OP, 1'b1, 32'h0000_FF0F);
        applyStimulus(1'b0, 16'h0);
        checkOutput("s4.idle", LOW_OP, 1'b0, 32'h0);

        applyStimulus(1'b1, 16'hABCD);
        call = 1'b0;
        checkOutput("s5.low", LOW_OP, 1'b1, 32'h0000_ABCD);
        #2 reset = 1'b1;
        #1 checkOutput("s5.async", LOW_OP, 1'b0, 32'h0);
        #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0);
            checkOutput("s5.after", LOW_OP, 1'b0, 32'h0);
        end

`ifdef CALL_FSM_PENDING_EN
        heldOut   = '{LOW_OP, HIGH_OP, LOW_OP, HIGH_OP, LOW_OP, HIGH_OP};
        heldStall = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        heldPc    = '{32'h5A5A, 32'h5A5A, 32'h5A5A, 32'h5A5A, 32'h5A5A, 32'h5A5A};
`else
        heldOut   = '{LOW_OP, HIGH_OP, LOW_OP, LOW_OP, HIGH_OP, LOW_OP};
        heldStall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        heldPc    = '{32'h5A5A, 32'h5A5A, 32'h0, 32'h5A5A, 32'h5A5A, 32'h0};
`endif
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 16'h5A5A);
            checkOutput($sformatf("s6.held%0d", i), heldOut[i], heldStall[i], heldPc[i]);
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0);
        checkOutput("final.idle", LOW_OP, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
